// File: rtl/deser_lane_arbiter.sv
// Round-robin arbiter sharing one serial-to-parallel deserializer among several lanes.
// Grants one lane per word, tags completed words and flushes the deserializer on a stalled lane.
module deser_lane_arbiter #(
  parameter  int NUM_LANES    = 4,
  parameter  int WORD_W       = 16,
  parameter  int IDLE_TIMEOUT = 32,
  localparam int LANE_W       = $clog2(NUM_LANES)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [NUM_LANES-1:0] lane_req_i,
  input  logic [NUM_LANES-1:0] lane_data_i,
  input  logic [NUM_LANES-1:0] lane_data_val_i,
  output logic [NUM_LANES-1:0] lane_gnt_o,
  output logic                 deser_srst_o,
  output logic                 deser_data_o,
  output logic                 deser_data_val_o,
  input  logic                 deser_word_val_i,
  output logic                 word_val_o,
  output logic [LANE_W-1:0]    word_lane_o,
  output logic                 abort_o,
  output logic [LANE_W-1:0]    abort_lane_o,
  output logic                 sync_err_o
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int TMR_W = $clog2(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FLUSH
  } state_e;

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    g_q, g_d;
  logic [LANE_W-1:0]    last_q, last_d;
  logic [NUM_LANES-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 sync_err_q, sync_err_d;

  logic [LANE_W-1:0]    pick;
  logic                 pick_vld;
  logic                 bit_vld;
  logic                 bit_dat;
  logic                 completing;

  function automatic logic [LANE_W-1:0] rr_lane(input logic [LANE_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_LANES) sum = sum - NUM_LANES;
    return LANE_W'(sum);
  endfunction

  // Scan downward in offset so the nearest requester after last_q is written last and wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      if (lane_req_i[rr_lane(last_q, i)]) begin
        pick     = rr_lane(last_q, i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    sync_err_d = sync_err_q;
    bit_vld    = 1'b0;
    bit_dat    = 1'b0;
    completing = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d   = ST_BUSY;
          g_d       = pick;
          gnt_d     = {{(NUM_LANES-1){1'b0}}, 1'b1} << pick;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end
      ST_BUSY: begin
        bit_vld    = lane_data_val_i[g_q];
        bit_dat    = lane_data_i[g_q];
        completing = bit_vld && (bit_cnt_q == CNT_W'(WORD_W - 1));
        // The deserializer must report a word exactly on our completing bit.
        if (deser_word_val_i != completing) sync_err_d = 1'b1;
        if (bit_vld) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (completing) begin
            state_d   = ST_IDLE;
            last_d    = g_q;
            gnt_d     = '0;
            bit_cnt_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TMR_W'(IDLE_TIMEOUT - 1)) begin
            state_d = ST_FLUSH;
            gnt_d   = '0;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        last_d  = g_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      last_q     <= LANE_W'(NUM_LANES - 1);
      gnt_q      <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign lane_gnt_o       = gnt_q;
  assign deser_srst_o     = srst_i | (state_q == ST_FLUSH);
  assign deser_data_o     = bit_dat;
  assign deser_data_val_o = bit_vld;
  assign word_val_o       = deser_word_val_i & (state_q == ST_BUSY);
  assign word_lane_o      = g_q;
  assign abort_o          = (state_q == ST_FLUSH);
  assign abort_lane_o     = (state_q == ST_FLUSH) ? g_q : '0;
  assign sync_err_o       = sync_err_q;

endmodule

// File: tb/tb_deser_lane_arbiter.sv
// Bench for deser_lane_arbiter: directed scenarios plus random traffic against a
// transaction-level model that tracks grants, word progress and stall deadlines in absolute cycles.
module tb_deser_lane_arbiter;
  localparam int N  = 4;
  localparam int WW = 16;
  localparam int TO = 32;
  localparam int LW = $clog2(N);

  logic          clk = 1'b0;
  logic          srst;
  logic [N-1:0]  lane_req, lane_data, lane_val, gnt;
  logic          dsrst, ddata, dval, dwv, wval, abort, serr;
  logic [LW-1:0] wlane, alane;

  int checks = 0;
  int errors = 0;

  // Model: which lane owns the deserializer, how far its word has got, and when it last showed life.
  int            busyLane, flushLane, bitsGot, lastActivity, lastServed, tagLane, cycleNo;
  bit            stickyErr;
  logic [WW-1:0] expWord, obsWord;
  logic [N-1:0]  prevGnt;
  int            gntLog[$];
  int            lastAbortCycle;

  always #5 clk = ~clk;

  deser_lane_arbiter #(.NUM_LANES(N), .WORD_W(WW), .IDLE_TIMEOUT(TO)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .lane_req_i       (lane_req),
    .lane_data_i      (lane_data),
    .lane_data_val_i  (lane_val),
    .lane_gnt_o       (gnt),
    .deser_srst_o     (dsrst),
    .deser_data_o     (ddata),
    .deser_data_val_o (dval),
    .deser_word_val_i (dwv),
    .word_val_o       (wval),
    .word_lane_o      (wlane),
    .abort_o          (abort),
    .abort_lane_o     (alane),
    .sync_err_o       (serr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNo);
    end
  endtask

  task automatic modelReset();
    busyLane   = -1;
    flushLane  = -1;
    bitsGot    = 0;
    lastServed = N - 1;
    tagLane    = 0;
    stickyErr  = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] val,
                               input logic [N-1:0] data, input logic rst, input logic forceWv);
    logic [N-1:0] eGnt;
    logic         eData, eVal, eWv, done, v;
    int           pickLane;
    lane_req  = req;
    lane_val  = val;
    lane_data = data;
    srst      = rst;
    v   = (busyLane >= 0) ? val[busyLane] : 1'b0;
    dwv = forceWv || (v && bitsGot == WW - 1);
    #4;
    eGnt  = (busyLane >= 0) ? (N'(1) << busyLane) : '0;
    eData = (busyLane >= 0) ? data[busyLane] : 1'b0;
    eVal  = v;
    eWv   = (busyLane >= 0) && dwv;
    checkOutput("lane_gnt", 32'(gnt), 32'(eGnt));
    checkOutput("deser_srst", 32'(dsrst), 32'(rst || flushLane >= 0));
    checkOutput("deser_data", 32'(ddata), 32'(eData));
    checkOutput("deser_val", 32'(dval), 32'(eVal));
    checkOutput("word_val", 32'(wval), 32'(eWv));
    checkOutput("word_lane", 32'(wlane), 32'(tagLane));
    checkOutput("abort", 32'(abort), 32'(flushLane >= 0));
    if (flushLane >= 0) checkOutput("abort_lane", 32'(alane), 32'(flushLane));
    checkOutput("sync_err", 32'(serr), 32'(stickyErr));
    if (dval === 1'b1) obsWord = {obsWord[WW-2:0], ddata};
    if (abort === 1'b1) lastAbortCycle = cycleNo;
    if (gnt !== '0 && gnt !== prevGnt) begin
      for (int i = 0; i < N; i++) if (gnt[i]) gntLog.push_back(i);
    end
    prevGnt = gnt;

    if (rst) begin
      modelReset();
    end else if (flushLane >= 0) begin
      lastServed = flushLane;
      flushLane  = -1;
    end else if (busyLane >= 0) begin
      done = v && (bitsGot == WW - 1);
      if (dwv != done) stickyErr = 1'b1;
      if (v) begin
        expWord      = {expWord[WW-2:0], data[busyLane]};
        bitsGot      = bitsGot + 1;
        lastActivity = cycleNo;
      end
      if (done) begin
        checkOutput("word_data", 32'(obsWord), 32'(expWord));
        lastServed = busyLane;
        busyLane   = -1;
      end else if (!v && (cycleNo + 1 - lastActivity == TO)) begin
        flushLane = busyLane;
        busyLane  = -1;
      end
    end else if (req != '0) begin
      pickLane = -1;
      for (int k = 1; k <= N; k++) begin
        if (pickLane < 0 && req[(lastServed + k) % N]) pickLane = (lastServed + k) % N;
      end
      busyLane     = pickLane;
      tagLane      = pickLane;
      bitsGot      = 0;
      lastActivity = cycleNo;
      expWord      = '0;
    end
    cycleNo++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0]  word;
    logic [N-1:0] rq, vl;
    int           t0, pct;
    srst = 1'b1; lane_req = '0; lane_data = '0; lane_val = '0; dwv = 1'b0;
    cycleNo = 0; obsWord = '0; expWord = '0; prevGnt = '0; lastAbortCycle = -1;
    modelReset();
    @(posedge clk);
    #1;
    applyStimulus('0, '0, '0, 1'b1, 1'b0);

    $display("[TB] single lane 2 word 0xA5C3");
    word = 16'hA5C3;
    applyStimulus(4'b0100, '0, '0, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--)
      applyStimulus((i == 15) ? 4'b0100 : 4'b0000, 4'b0100, N'(word[i]) << 2, 1'b0, 1'b0);
    checkOutput("word_a5c3", 32'(obsWord), 32'(word));
    checkOutput("lane2_tag", 32'(wlane), 32'd2);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, '0, 1'b0, 1'b0);

    $display("[TB] round robin lanes 0,1,3");
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    gntLog.delete();
    for (int i = 0; i < 105; i++) applyStimulus(4'b1011, 4'b1111, N'($urandom), 1'b0, 1'b0);
    begin
      int expOrder[6] = '{0, 1, 3, 0, 1, 3};
      for (int i = 0; i < 6; i++)
        checkOutput("rr_order", (i < gntLog.size()) ? 32'(gntLog[i]) : 32'hFFFF_FFFF, 32'(expOrder[i]));
    end

    $display("[TB] gapped bits on lane 1");
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++)
      applyStimulus((k == 0) ? 4'b0010 : 4'b0000, (k % 6 == 0) ? 4'b0010 : 4'b0000,
                    N'($urandom), 1'b0, 1'b0);
    checkOutput("gap_tag", 32'(wlane), 32'd1);
    checkOutput("gap_no_abort", 32'(lastAbortCycle), 32'hFFFF_FFFF);

    $display("[TB] timeout on lane 0");
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    t0 = cycleNo;
    for (int k = 0; k < 62; k++) begin
      rq = (k == 0) ? 4'b0011 : 4'b0010;
      vl = (k >= 1 && k <= 7) ? 4'b0011 : 4'b0010;
      applyStimulus(rq, vl, N'($urandom), 1'b0, 1'b0);
    end
    checkOutput("abort_time", 32'(lastAbortCycle - t0), 32'd39);
    checkOutput("after_abort_tag", 32'(wlane), 32'd1);

    $display("[TB] reset mid-word on lane 3");
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++)
      applyStimulus((k == 0) ? 4'b1000 : 4'b0000, (k >= 1) ? 4'b1000 : 4'b0000,
                    N'($urandom), 1'b0, 1'b0);
    applyStimulus(4'b1001, '0, '0, 1'b1, 1'b0);
    gntLog.delete();
    for (int k = 0; k < 20; k++) applyStimulus(4'b1001, 4'b1111, N'($urandom), 1'b0, 1'b0);
    checkOutput("post_reset_first", (gntLog.size() > 0) ? 32'(gntLog[0]) : 32'hFFFF_FFFF, 32'd0);

    $display("[TB] forced word-valid on bit 8");
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++)
      applyStimulus((k == 0) ? 4'b0001 : 4'b0000, 4'b0001, N'($urandom), 1'b0,
                    (busyLane == 0) && (bitsGot == 7));
    checkOutput("sync_set", 32'(serr), 32'd1);
    for (int k = 0; k < 10; k++) applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkOutput("sync_sticky", 32'(serr), 32'd1);
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    checkOutput("sync_cleared", 32'(serr), 32'd0);

    $display("[TB] random traffic");
    for (int e = 0; e < 20; e++) begin
      case (e % 3)
        0:       pct = 90;
        1:       pct = 50;
        default: pct = 3;
      endcase
      for (int k = 0; k < 200; k++) begin
        for (int l = 0; l < N; l++) vl[l] = ($urandom_range(99) < pct);
        rq = ($urandom_range(3) == 0) ? '0 : N'($urandom);
        applyStimulus(rq, vl, N'($urandom), ($urandom_range(399) == 0),
                      ($urandom_range(249) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
